// File: rtl/ldm_stm_sequencer_if.sv
// LDM/STM sequencer bus: control inputs and register-file/memory strobes.
// master drives the instruction fields, slave is the sequencer itself.
interface ldm_stm_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int LIST_W = 16
);
  logic              Start;
  logic              IsLoad;
  logic              PBit;
  logic              UBit;
  logic              WBit;
  logic [3:0]        BaseReg;
  logic [ADDR_W-1:0] BaseAddr;
  logic [LIST_W-1:0] RegList;
  logic [3:0]        RegAddr;
  logic              RegWriteEnable;
  logic              WbSelBase;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemWrite;
  logic [ADDR_W-1:0] NewBase;
  logic              Busy;
  logic              Done;

  modport master (
    output Start, IsLoad, PBit, UBit, WBit,
    output BaseReg, BaseAddr, RegList,
    input  RegAddr, RegWriteEnable, WbSelBase,
    input  MemAddr, MemWrite, NewBase, Busy, Done
  );

  modport slave (
    input  Start, IsLoad, PBit, UBit, WBit,
    input  BaseReg, BaseAddr, RegList,
    output RegAddr, RegWriteEnable, WbSelBase,
    output MemAddr, MemWrite, NewBase, Busy, Done
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer, one register access per cycle.
// Base writeback cycle enabled by defining LSM_WRITEBACK_EN.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int LIST_W = 16
) (
  input logic CLK,
  input logic RESETn,
  ldm_stm_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, XFER, WB, DONE
  } state_t;

  localparam int LW = LIST_W - 1;
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(4);

  state_t          state;
  logic [LW-1:0]   pending;
  logic            isLoad;
  logic [LW-1:0]   startList;
  logic [4:0]      cnt;
  logic [ADDR_W-1:0] fourN;
  logic [ADDR_W-1:0] startAddr;
  logic [ADDR_W-1:0] endBase;
`ifdef LSM_WRITEBACK_EN
  logic [3:0]      baseReg;
  logic            wbPend;
  logic [LW:0]     extList;
  logic            wbReq;
`endif

  function automatic logic [3:0] lowIdx(
    input logic [LW-1:0] v
  );
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = LW - 1; i >= 0; i--)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  function automatic logic [LW-1:0] clrLow(
    input logic [LW-1:0] v
  );
    return v & (v - LW'(1));
  endfunction

  // bit 15 (PC) never transfers
  assign startList = bus.RegList[LW-1:0];

  // transfer count and start/end addresses
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < LW; i++)
      cnt = cnt + 5'(startList[i]);
    fourN = ADDR_W'({cnt, 2'b00});
    startAddr = bus.BaseAddr;
    unique case (1'b1)
      ( bus.UBit && !bus.PBit):
        startAddr = bus.BaseAddr;
      ( bus.UBit &&  bus.PBit):
        startAddr = bus.BaseAddr + STEP;
      (!bus.UBit && !bus.PBit):
        startAddr = bus.BaseAddr - fourN + STEP;
      (!bus.UBit &&  bus.PBit):
        startAddr = bus.BaseAddr - fourN;
      default:
        startAddr = bus.BaseAddr;
    endcase
    endBase = bus.UBit
      ? bus.BaseAddr + fourN
      : bus.BaseAddr - fourN;
  end

`ifdef LSM_WRITEBACK_EN
  // a loaded base wins over writeback
  assign extList = {1'b0, startList};
  assign wbReq = bus.WBit &&
    !(bus.IsLoad && extList[bus.BaseReg]);
`else
  assign bus.WbSelBase = 1'b0;
`endif

  // sequencer FSM with registered outputs
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state              <= IDLE;
      pending            <= '0;
      isLoad             <= 1'b0;
      bus.RegAddr        <= 4'd0;
      bus.RegWriteEnable <= 1'b0;
      bus.MemAddr        <= '0;
      bus.MemWrite       <= 1'b0;
      bus.NewBase        <= '0;
      bus.Busy           <= 1'b0;
      bus.Done           <= 1'b0;
`ifdef LSM_WRITEBACK_EN
      baseReg            <= 4'd0;
      wbPend             <= 1'b0;
      bus.WbSelBase      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          bus.Done <= 1'b0;
          if (bus.Start) begin
            isLoad      <= bus.IsLoad;
            bus.NewBase <= endBase;
            bus.Busy    <= 1'b1;
`ifdef LSM_WRITEBACK_EN
            baseReg     <= bus.BaseReg;
            wbPend      <= wbReq;
`endif
            if (|startList) begin
              state   <= XFER;
              pending <= clrLow(startList);
              bus.RegAddr <= lowIdx(startList);
              bus.MemAddr <= startAddr;
              bus.RegWriteEnable <= bus.IsLoad;
              bus.MemWrite <= !bus.IsLoad;
            end else begin
              state    <= DONE;
              bus.Done <= 1'b1;
            end
          end
        end
        XFER: begin
          if (|pending) begin
            pending     <= clrLow(pending);
            bus.RegAddr <= lowIdx(pending);
            bus.MemAddr <= bus.MemAddr + STEP;
`ifdef LSM_WRITEBACK_EN
          end else if (wbPend) begin
            state              <= WB;
            bus.RegAddr        <= baseReg;
            bus.RegWriteEnable <= 1'b1;
            bus.WbSelBase      <= 1'b1;
            bus.MemWrite       <= 1'b0;
`endif
          end else begin
            state              <= DONE;
            bus.Done           <= 1'b1;
            bus.RegWriteEnable <= 1'b0;
            bus.MemWrite       <= 1'b0;
          end
        end
`ifdef LSM_WRITEBACK_EN
        WB: begin
          state              <= DONE;
          bus.Done           <= 1'b1;
          bus.RegWriteEnable <= 1'b0;
          bus.WbSelBase      <= 1'b0;
        end
`endif
        DONE: begin
          state    <= IDLE;
          bus.Done <= 1'b0;
          bus.Busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: directed plan plus random transfers
// checked against a per-cycle expectation list built from the rules.
module tb_ldm_stm_sequencer;
  typedef struct {
    logic [3:0]  ra;
    logic [31:0] ma;
    logic        rwe;
    logic        wbs;
    logic        mw;
    logic        done;
    logic        busy;
  } exp_t;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  ldm_stm_sequencer_if #(.ADDR_W(32), .LIST_W(16)) bus ();

  ldm_stm_sequencer #(.ADDR_W(32), .LIST_W(16)) dut (
    .CLK(CLK),
    .RESETn(RESETn),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0]  lastRa = 4'd0;
  logic [31:0] lastMa = 32'd0;
  logic [31:0] expNb = 32'd0;
  exp_t q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".RegAddr"}, 32'(bus.RegAddr), 32'(e.ra));
    chk({tag, ".MemAddr"}, bus.MemAddr, e.ma);
    chk({tag, ".RegWE"}, 32'(bus.RegWriteEnable), 32'(e.rwe));
    chk({tag, ".WbSel"}, 32'(bus.WbSelBase), 32'(e.wbs));
    chk({tag, ".MemWrite"}, 32'(bus.MemWrite), 32'(e.mw));
    chk({tag, ".Done"}, 32'(bus.Done), 32'(e.done));
    chk({tag, ".Busy"}, 32'(bus.Busy), 32'(e.busy));
  endtask

  // Expected per-cycle outputs from Start+1 until back in idle
  task automatic build(input logic ld, input logic p,
                       input logic u, input logic w,
                       input logic [3:0] br,
                       input logic [31:0] base,
                       input logic [15:0] list);
    int n;
    int k;
    logic [31:0] a0;
    logic wb;
    exp_t e;
    q.delete();
    n = 0;
    for (int i = 0; i < 15; i++) if (list[i]) n++;
    if (u) a0 = base + (p ? 32'd4 : 32'd0);
    else   a0 = base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
    expNb = u ? base + 32'(4 * n) : base - 32'(4 * n);
    k = 0;
    for (int i = 0; i < 15; i++) begin
      if (list[i]) begin
        lastRa = 4'(i);
        lastMa = a0 + 32'(4 * k);
        e = '{lastRa, lastMa, ld, 1'b0, !ld, 1'b0, 1'b1};
        q.push_back(e);
        k++;
      end
    end
`ifdef LSM_WRITEBACK_EN
    wb = w && !(ld && br != 4'd15 && list[br]);
`else
    wb = 1'b0;
`endif
    if (wb) begin
      lastRa = br;
      e = '{lastRa, lastMa, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      q.push_back(e);
    end
    e = '{lastRa, lastMa, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    q.push_back(e);
    e = '{lastRa, lastMa, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    q.push_back(e);
  endtask

  task automatic drive(input logic ld, input logic p,
                       input logic u, input logic w,
                       input logic [3:0] br,
                       input logic [31:0] base,
                       input logic [15:0] list);
    bus.IsLoad   = ld;
    bus.PBit     = p;
    bus.UBit     = u;
    bus.WBit     = w;
    bus.BaseReg  = br;
    bus.BaseAddr = base;
    bus.RegList  = list;
    bus.Start    = 1'b1;
  endtask

  task automatic runTxn(input string tag,
                        input logic ld, input logic p,
                        input logic u, input logic w,
                        input logic [3:0] br,
                        input logic [31:0] base,
                        input logic [15:0] list);
    build(ld, p, u, w, br, base, list);
    @(negedge CLK);
    drive(ld, p, u, w, br, base, list);
    @(posedge CLK);
    #1 bus.Start = 1'b0;
    bus.RegList = 16'($urandom);
    bus.BaseAddr = $urandom;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge CLK);
      cmp($sformatf("%s.c%0d", tag, i + 1), q[i]);
      chk($sformatf("%s.c%0d.NewBase", tag, i + 1),
          bus.NewBase, expNb);
    end
  endtask

  initial begin
    exp_t idle0;
    bus.Start = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 16'd0);
    bus.Start = 1'b0;
    idle0 = '{4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge CLK);
    cmp("reset", idle0);
    chk("reset.NewBase", bus.NewBase, 32'd0);
    RESETn = 1'b1;
    @(negedge CLK);
    cmp("postreset", idle0);

    runTxn("ldm_ia_wb", 1'b1, 1'b0, 1'b1, 1'b1,
           4'd13, 32'h100, 16'h0005);
    runTxn("stm_db", 1'b0, 1'b1, 1'b0, 1'b0,
           4'd2, 32'h200, 16'h4002);
    runTxn("empty", 1'b1, 1'b0, 1'b1, 1'b1,
           4'd5, 32'h400, 16'h8000);
    runTxn("ldm_base_in_list", 1'b1, 1'b0, 1'b1, 1'b1,
           4'd3, 32'h500, 16'h0008);
    runTxn("stm_wrap", 1'b0, 1'b0, 1'b1, 1'b1,
           4'd0, 32'hFFFF_FFF0, 16'hFFFF);
    runTxn("ldm_da", 1'b1, 1'b0, 1'b0, 1'b1,
           4'd15, 32'h1000, 16'h0C21);
    runTxn("stm_ib", 1'b0, 1'b1, 1'b1, 1'b1,
           4'd7, 32'h0000_0004, 16'h0081);

    // reset during the 2nd transfer, Start while busy ignored
    build(1'b1, 1'b0, 1'b1, 1'b0, 4'd1,
          32'h300, 16'h00F0);
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd1,
          32'h300, 16'h00F0);
    @(posedge CLK);
    #1 bus.Start = 1'b0;
    @(negedge CLK);
    cmp("rst.c1", q[0]);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd9,
          32'h9999, 16'h0001);
    @(posedge CLK);
    #1 bus.Start = 1'b0;
    @(negedge CLK);
    cmp("rst.c2", q[1]);
    chk("rst.c2.NewBase", bus.NewBase, expNb);
    #1 RESETn = 1'b0;
    #1;
    cmp("rst.async", idle0);
    chk("rst.async.NewBase", bus.NewBase, 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    lastRa = 4'd0;
    lastMa = 32'd0;
    repeat (2) @(negedge CLK);
    cmp("rst.after", idle0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] l;
      l = 16'($urandom);
      if (t % 8 == 0) l = 16'($urandom) & 16'h8000;
      if (t % 8 == 1) l = 16'h0001 << $urandom_range(0, 14);
      runTxn($sformatf("rnd%0d", t),
             1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom),
             4'($urandom), $urandom, l);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "timeout");
  end
endmodule
